// File: rtl/multi_scan_pkg.sv
// Shared types and helpers for the multi-chain scan register bank.
package multi_scan_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } scan_state_e;

  // Width of the burst shift counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned seg_len);
    int unsigned w;
    w = $clog2(seg_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_segment.sv
// One scan segment: parallel-loadable shift register whose MSB is the serial output.
module scan_segment #(
  parameter int unsigned       SegLen     = 4,
  parameter logic [SegLen-1:0] ResetValue = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [SegLen-1:0] load_data_i,
  input  logic              shift_i,
  input  logic              serial_i,
  output logic [SegLen-1:0] data_o,
  output logic              msb_o
);

  logic [SegLen-1:0] seg_q, seg_d;

  always_comb begin
    seg_d = seg_q;
    if (load_i) begin
      seg_d = load_data_i;
    end else if (shift_i) begin
      seg_d = {seg_q[SegLen-2:0], serial_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg_q <= ResetValue;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign data_o = seg_q;
  assign msb_o  = seg_q[SegLen-1];

endmodule

// File: rtl/multi_scan_register.sv
// Register bank with parallel load and CHAINS scan segments shifted in counted bursts.
// Optional feature: define MULTI_SCAN_ROTATE_EN for non-destructive rotate-readout bursts.
module multi_scan_register
  import multi_scan_pkg::*;
#(
  parameter int unsigned      WIDTH       = 12,
  parameter int unsigned      CHAINS      = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  input  logic              scan_start,
  input  logic              scan_enable,
`ifdef MULTI_SCAN_ROTATE_EN
  input  logic              scan_rotate,
`endif
  input  logic [CHAINS-1:0] scan_in,
  output logic [CHAINS-1:0] scan_out,
  output logic              scan_busy,
  output logic              scan_done
);

  localparam int unsigned SegLen = WIDTH / CHAINS;
  localparam int unsigned CntW   = cnt_width(SegLen);

  scan_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            shift;
  logic            rotate_active;
  logic [CHAINS-1:0] msb;

`ifdef MULTI_SCAN_ROTATE_EN
  logic rot_q;
  assign rotate_active = (state_q == StShift) && rot_q;
`else
  assign rotate_active = 1'b0;
`endif

  // Load always wins; single-steps only when idle and no burst is being requested.
  always_comb begin
    shift = 1'b0;
    if (!enable) begin
      if (state_q == StShift) begin
        shift = 1'b1;
      end else if (!scan_start && scan_enable) begin
        shift = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef MULTI_SCAN_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!enable && scan_start) begin
            state_q <= StShift;
            cnt_q   <= CntW'(SegLen - 1);
`ifdef MULTI_SCAN_ROTATE_EN
            rot_q   <= scan_rotate;
`endif
          end
        end
        StShift: begin
          if (enable) begin
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar c = 0; c < CHAINS; c++) begin : g_seg
    logic ser;
    assign ser = rotate_active ? msb[c] : scan_in[c];

    scan_segment #(
      .SegLen    (SegLen),
      .ResetValue(RESET_VALUE[c*SegLen +: SegLen])
    ) u_seg (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (enable),
      .load_data_i(data_in[c*SegLen +: SegLen]),
      .shift_i    (shift),
      .serial_i   (ser),
      .data_o     (data_out[c*SegLen +: SegLen]),
      .msb_o      (msb[c])
    );
  end

  assign scan_out  = msb;
  assign scan_busy = (state_q == StShift);
  assign scan_done = done_q;

endmodule
